// File: rtl/wasca_switches_pkg.sv
// rtl/wasca_switches_pkg.sv - shared defaults and width helper for the switch debounce block
package wasca_switches_pkg;

  localparam int DEF_WIDTH        = 3;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 8;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wasca_debounce_bit.sv
// rtl/wasca_debounce_bit.sv - one switch bit: 2-FF synchroniser, tick-based debounce, edge pulses
module wasca_debounce_bit
  import wasca_switches_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  input  logic tick,
  output logic sw_debounced,
  output logic sw_rise,
  output logic sw_fall,
  output logic accept
);

  localparam int              CW      = clog2_min1(STABLE_TICKS);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_TICKS - 1);

  logic          sync_q1;
  logic          sw_sync;
  logic [CW-1:0] cnt;

  // Goes high on the tick where the new level has differed for the full run.
  assign accept = tick && (sw_sync != sw_debounced) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1      <= 1'b0;
      sw_sync      <= 1'b0;
      cnt          <= '0;
      sw_debounced <= 1'b0;
      sw_rise      <= 1'b0;
      sw_fall      <= 1'b0;
    end else begin
      sync_q1 <= sw_raw;
      sw_sync <= sync_q1;
      sw_rise <= accept & sw_sync;
      sw_fall <= accept & ~sw_sync;
      if (tick) begin
        if (sw_sync == sw_debounced) begin
          cnt <= '0;
        end else if (accept) begin
          sw_debounced <= sw_sync;
          cnt          <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wasca_switches_debounce.sv
// rtl/wasca_switches_debounce.sv - switch conditioning ahead of the switches PIO: shared prescaler plus per-bit debounce
module wasca_switches_debounce
  import wasca_switches_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int            TW       = clog2_min1(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] accept;

  assign tick = (tick_cnt == TICK_MAX);

  // Free-running sample clock shared by all bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wasca_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk         (clk),
      .reset_n     (reset_n),
      .sw_raw      (sw_raw[i]),
      .tick        (tick),
      .sw_debounced(sw_debounced[i]),
      .sw_rise     (sw_rise[i]),
      .sw_fall     (sw_fall[i]),
      .accept      (accept[i])
    );
  end

  // Registered from the same accept terms so it lines up with the rise/fall pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= |accept;
    end
  end

endmodule

// File: tb/tb_wasca_switches_debounce.sv
// tb/tb_wasca_switches_debounce.sv - directed and random checks of the switch debounce block against a cycle model
module tb_wasca_switches_debounce;

  localparam int W  = 3;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_debounced;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  wasca_switches_debounce #(
    .WIDTH       (W),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_raw      (sw_raw),
    .sw_debounced(sw_debounced),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .sw_changed  (sw_changed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: raw samples seen 1 and 2 edges ago, accepted levels, and
  // per-bit run length of consecutive ticks that saw a differing level.
  logic [W-1:0] p1, p2, m_stable, m_rise, m_fall;
  logic         m_changed;
  int           run [W];
  int           cyc;
  int           rises_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p1 = '0; p2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
    for (int i = 0; i < W; i++) run[i] = 0;
    cyc = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw);
    m_rise = '0;
    m_fall = '0;
    if ((cyc % TD) == TD - 1) begin
      for (int i = 0; i < W; i++) begin
        if (p2[i] != m_stable[i]) begin
          run[i]++;
          if (run[i] == ST) begin
            m_stable[i] = p2[i];
            run[i] = 0;
            if (p2[i]) m_rise[i] = 1'b1;
            else       m_fall[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
    m_changed = |(m_rise | m_fall);
    if (m_rise != '0) rises_seen++;
    p2 = p1;
    p1 = raw;
    cyc++;
  endtask

  task automatic compare_all();
    chk("debounced", 32'(sw_debounced), 32'(m_stable));
    chk("rise",      32'(sw_rise),      32'(m_rise));
    chk("fall",      32'(sw_fall),      32'(m_fall));
    chk("changed",   32'(sw_changed),   32'(m_changed));
    chk("tick",      32'(dut.tick),     32'((cyc % TD) == TD - 1));
  endtask

  // Called at a negedge: drive, clock, update model, compare at the next negedge.
  task automatic step(input logic [W-1:0] raw);
    sw_raw = raw;
    @(posedge clk);
    model_edge(raw);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw);
  endtask

  initial begin
    logic [W-1:0] r;
    int           k;
    rises_seen = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_debounced", 32'(sw_debounced), 32'h0);
    chk("reset_pulses",    32'({sw_rise, sw_fall, sw_changed}), 32'h0);
    reset_n = 1'b1;

    // 1. quiet inputs
    hold(3'b000, 100);
    // 2. single rise then fall
    hold(3'b001, 20);
    hold(3'b000, 20);
    // 3. bounce shorter than a full debounce run
    hold(3'b010, 7);
    hold(3'b000, 20);
    // 4. same-cycle rise and fall on different bits
    hold(3'b100, 20);
    hold(3'b001, 20);

    // 6. one-cycle glitch that the synchroniser delivers between ticks
    k = 0;
    while ((cyc % TD) != 0 && k < TD) begin
      step(3'b001);
      k++;
    end
    step(3'b101);
    hold(3'b001, 20);

    // 5. async reset after one counted tick, then re-acceptance from zero
    hold(3'b111, 2 + TD);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_debounced", 32'(sw_debounced), 32'h0);
    chk("async_reset_changed",   32'(sw_changed),   32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    hold(3'b111, 20);
    chk("rise_111_after_reset", 32'(sw_debounced), 32'h7);

    // Random slow toggling so some changes survive debounce and some do not
    r = 3'b111;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) r = r ^ W'(1 << $urandom_range(0, W - 1));
      step(r);
    end
    chk("random_rises_seen", 32'(rises_seen > 3), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
